// File: rtl/result_bcd_converter_pkg.sv
// -----------------------------------------------------------------------------
// mrc_pkg
//   Shared definitions for the result-to-BCD converter slice: default sizing
//   constants and the converter FSM state type.
//
//   WORD_LENGTH_DEF : operand width of the upstream calculator (result is 2x)
//   DIGITS_DEF      : BCD digits needed to hold |result| for the default width
//                     (10^10 > 2^31)
//   state_e         : converter control states
// -----------------------------------------------------------------------------
package mrc_pkg;

    localparam int WORD_LENGTH_DEF = 16;
    localparam int DIGITS_DEF      = 10;

    // IDLE waits for a rising edge of ready, SHIFT runs the double-dabble
    // loop, DONE publishes the outputs for one cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : mrc_pkg

// File: rtl/result_bcd_converter_if.sv
// -----------------------------------------------------------------------------
// result_bcd_converter_if
//   Bundle between the calculator stage and the BCD converter.
//
//   Calculator -> converter:
//     Result  [2*WORD_LENGTH] signed two's-complement result
//     ready   result-valid level; rising edge starts a conversion
//     error   calculator error flag, sampled with Result
//   Converter -> downstream:
//     bcd     [4*DIGITS] packed BCD magnitude, digit 0 in bits [3:0]
//     sign    captured result was negative
//     err_out captured result carried the error flag
//     busy    conversion in progress
//     done    one-cycle pulse when bcd/sign/err_out update
//
//   Modports: master = calculator side, slave = converter side.
// -----------------------------------------------------------------------------
interface result_bcd_converter_if
    import mrc_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEF,
    parameter int DIGITS      = DIGITS_DEF
) ();

    logic [2*WORD_LENGTH-1:0] Result;
    logic                     ready;
    logic                     error;
    logic [4*DIGITS-1:0]      bcd;
    logic                     sign;
    logic                     err_out;
    logic                     busy;
    logic                     done;

    modport master (
        output Result,
        output ready,
        output error,
        input  bcd,
        input  sign,
        input  err_out,
        input  busy,
        input  done
    );

    modport slave (
        input  Result,
        input  ready,
        input  error,
        output bcd,
        output sign,
        output err_out,
        output busy,
        output done
    );

endinterface : result_bcd_converter_if

// File: rtl/result_bcd_converter_bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//   Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so that
//   the following left shift carries correctly into the next decimal digit.
//
//   digit_i [4] : working BCD digit before correction
//   digit_o [4] : corrected digit (digit_i + 3 when digit_i >= 5)
// -----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule : bcd_add3

// File: rtl/result_bcd_converter.sv
// -----------------------------------------------------------------------------
// result_bcd_converter
//   Converts the signed calculator result into sign + packed BCD magnitude
//   using a serial double-dabble loop (one bit per clock).
//
//   Parameters:
//     WORD_LENGTH : calculator operand width; result is 2*WORD_LENGTH bits
//     DIGITS      : BCD digits, must satisfy 10^DIGITS > 2^(2*WORD_LENGTH-1)
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-low
//     bus   : slave side of result_bcd_converter_if (Result/ready/error in,
//             bcd/sign/err_out/busy/done out)
//
//   Timing (trigger sampled at edge k):
//     normal : SHIFT for edges k+1..k+2*WORD_LENGTH, outputs + done at
//              edge k+2*WORD_LENGTH+1
//     error  : outputs (all-F BCD, err_out=1) + done at edge k+1
// -----------------------------------------------------------------------------
module result_bcd_converter
    import mrc_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEF,
    parameter int DIGITS      = DIGITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    result_bcd_converter_if.slave   bus
);

    localparam int unsigned RW = 2 * WORD_LENGTH;
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = (RW > 1) ? $clog2(RW) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_d_q;
    logic [RW-1:0]   mag_q, mag_d;
    logic [BW-1:0]   work_q, work_d;
    logic            sign_cap_q, sign_cap_d;
    logic            err_cap_q, err_cap_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            sign_q, sign_d;
    logic            err_out_q, err_out_d;
    logic            done_q, done_d;

    logic            trigger;
    logic [BW-1:0]   work_adj;

    assign trigger = bus.ready & ~ready_d_q;

    // Per-digit add-3 correction applied to the working BCD register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (work_q[4*g +: 4]),
            .digit_o (work_adj[4*g +: 4])
        );
    end

    // ready_d_q keeps tracking ready while reset is asserted, so a ready level
    // already high at reset release is not seen as a rising edge.
    always_ff @(posedge clk) begin
        ready_d_q <= bus.ready;
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            work_q     <= '0;
            sign_cap_q <= 1'b0;
            err_cap_q  <= 1'b0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            err_out_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            work_q     <= work_d;
            sign_cap_q <= sign_cap_d;
            err_cap_q  <= err_cap_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            err_out_q  <= err_out_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        work_d     = work_q;
        sign_cap_d = sign_cap_q;
        err_cap_d  = err_cap_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        err_out_d  = err_out_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    sign_cap_d = bus.Result[RW-1];
                    // Unsigned negate: the most negative value maps to
                    // 2^(RW-1), which fits in RW unsigned bits.
                    mag_d      = bus.Result[RW-1] ? (~bus.Result + RW'(1))
                                                  : bus.Result;
                    err_cap_d  = bus.error;
                    work_d     = '0;
                    cnt_d      = '0;
                    state_d    = bus.error ? ST_DONE : ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                {work_d, mag_d} = {work_adj, mag_q} << 1;
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == CW'(RW - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done_d = 1'b1;
                if (err_cap_q) begin
                    bcd_d     = '1;
                    sign_d    = 1'b0;
                    err_out_d = 1'b1;
                end else begin
                    bcd_d     = work_q;
                    sign_d    = sign_cap_q;
                    err_out_d = 1'b0;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.bcd     = bcd_q;
    assign bus.sign    = sign_q;
    assign bus.err_out = err_out_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule : result_bcd_converter

// File: tb/tb_result_bcd_converter.sv
module tb_result_bcd_converter;

    localparam int W  = 16;
    localparam int D  = 10;
    localparam int RW = 2 * W;
    localparam int BW = 4 * D;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    result_bcd_converter_if #(.WORD_LENGTH(W), .DIGITS(D)) bus_if ();

    result_bcd_converter #(.WORD_LENGTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: decimal digits of |value| by plain integer arithmetic.
    function automatic logic [BW-1:0] model_bcd(input logic [RW-1:0] r);
        longint v;
        logic [BW-1:0] out;
        v = longint'($signed(r));
        if (v < 0) v = -v;
        out = '0;
        for (int i = 0; i < D; i++) begin
            out[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return out;
    endfunction

    function automatic logic model_sign(input logic [RW-1:0] r);
        return ($signed(r) < 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one conversion from a clean ready-low state and observes it.
    // lat counts edges from the trigger edge (1) to the edge that shows done.
    task automatic convert(input logic [RW-1:0] r, input logic e,
                           output int lat, output logic busy1,
                           output logic [BW-1:0] b, output logic s,
                           output logic eo, output logic done_next,
                           output logic [BW-1:0] b_next);
        int n;
        bus_if.ready = 1'b0;
        tick();
        bus_if.Result = r;
        bus_if.error  = e;
        bus_if.ready  = 1'b1;
        n = 0;
        lat = -1;
        busy1 = 1'b0;
        while (n < 100 && lat < 0) begin
            tick();
            n++;
            if (n == 1) begin
                busy1 = bus_if.busy;
                // Inputs changing after capture must not disturb the result.
                bus_if.Result = $urandom;
                bus_if.error  = 1'($urandom_range(0, 1));
            end
            if (bus_if.done === 1'b1) lat = n;
        end
        b  = bus_if.bcd;
        s  = bus_if.sign;
        eo = bus_if.err_out;
        bus_if.ready = 1'b0;
        bus_if.error = 1'b0;
        tick();
        done_next = bus_if.done;
        b_next    = bus_if.bcd;
    endtask

    task automatic test_reset();
        bus_if.ready  = 1'b0;
        bus_if.error  = 1'b0;
        bus_if.Result = '0;
        reset = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus_if.bcd !== '0) begin
            tests_failed++;
            $display("FAIL reset_bcd got=%h exp=%h", bus_if.bcd, {BW{1'b0}});
        end
        tests_run++;
        if (bus_if.sign !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sign got=%b exp=0", bus_if.sign);
        end
        tests_run++;
        if (bus_if.err_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err_out got=%b exp=0", bus_if.err_out);
        end
        tests_run++;
        if (bus_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy got=%b exp=0", bus_if.busy);
        end
        tests_run++;
        if (bus_if.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done got=%b exp=0", bus_if.done);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [RW-1:0] vals[5];
        int lat;
        logic busy1, s, eo, dn;
        logic [BW-1:0] b, bn;
        vals = '{32'hFFFFFF38, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF};
        foreach (vals[i]) begin
            convert(vals[i], 1'b0, lat, busy1, b, s, eo, dn, bn);
            tests_run++;
            if (lat !== RW + 2) begin
                tests_failed++;
                $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, RW + 2);
            end
            tests_run++;
            if (busy1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL dir_busy[%0d] got=%b exp=1", i, busy1);
            end
            tests_run++;
            if (b !== model_bcd(vals[i])) begin
                tests_failed++;
                $display("FAIL dir_bcd[%0d] in=%h got=%h exp=%h", i, vals[i], b, model_bcd(vals[i]));
            end
            tests_run++;
            if (s !== model_sign(vals[i])) begin
                tests_failed++;
                $display("FAIL dir_sign[%0d] got=%b exp=%b", i, s, model_sign(vals[i]));
            end
            tests_run++;
            if (eo !== 1'b0) begin
                tests_failed++;
                $display("FAIL dir_err_out[%0d] got=%b exp=0", i, eo);
            end
            tests_run++;
            if (dn !== 1'b0) begin
                tests_failed++;
                $display("FAIL dir_done_width[%0d] got=%b exp=0", i, dn);
            end
            tests_run++;
            if (bn !== model_bcd(vals[i])) begin
                tests_failed++;
                $display("FAIL dir_bcd_hold[%0d] got=%h exp=%h", i, bn, model_bcd(vals[i]));
            end
        end
    endtask

    task automatic test_error();
        int lat;
        logic busy1, s, eo, dn;
        logic [BW-1:0] b, bn;
        convert(32'hFFFFFF38, 1'b1, lat, busy1, b, s, eo, dn, bn);
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL err_latency got=%0d exp=2", lat);
        end
        tests_run++;
        if (b !== {BW{1'b1}}) begin
            tests_failed++;
            $display("FAIL err_bcd got=%h exp=%h", b, {BW{1'b1}});
        end
        tests_run++;
        if (s !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_sign got=%b exp=0", s);
        end
        tests_run++;
        if (eo !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_err_out got=%b exp=1", eo);
        end
        tests_run++;
        if (dn !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_done_width got=%b exp=0", dn);
        end
    endtask

    task automatic test_random();
        int lat;
        logic busy1, s, eo, dn;
        logic [BW-1:0] b, bn;
        logic [RW-1:0] r;
        logic e;
        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            e = ($urandom_range(0, 7) == 0);
            convert(r, e, lat, busy1, b, s, eo, dn, bn);
            tests_run++;
            if (lat !== (e ? 2 : RW + 2)) begin
                tests_failed++;
                $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, lat, e ? 2 : RW + 2);
            end
            tests_run++;
            if (b !== (e ? {BW{1'b1}} : model_bcd(r))) begin
                tests_failed++;
                $display("FAIL rnd_bcd[%0d] in=%h err=%b got=%h exp=%h", i, r, e, b,
                         e ? {BW{1'b1}} : model_bcd(r));
            end
            tests_run++;
            if (s !== (e ? 1'b0 : model_sign(r))) begin
                tests_failed++;
                $display("FAIL rnd_sign[%0d] got=%b exp=%b", i, s, e ? 1'b0 : model_sign(r));
            end
            tests_run++;
            if (eo !== e) begin
                tests_failed++;
                $display("FAIL rnd_err_out[%0d] got=%b exp=%b", i, eo, e);
            end
        end
    endtask

    task automatic test_held_ready();
        int dones;
        int extra;
        bus_if.ready  = 1'b0;
        bus_if.error  = 1'b0;
        bus_if.Result = 32'd12345;
        tick();
        bus_if.ready = 1'b1;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_if.done === 1'b1) dones++;
            // Second rising edge of ready while the first conversion is busy.
            if (i == 10) bus_if.ready = 1'b0;
            if (i == 11) bus_if.ready = 1'b1;
        end
        bus_if.ready = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.done === 1'b1) extra++;
        end
        tests_run++;
        if (dones !== 1) begin
            tests_failed++;
            $display("FAIL held_ready_dones got=%0d exp=1", dones);
        end
        tests_run++;
        if (extra !== 0) begin
            tests_failed++;
            $display("FAIL held_ready_late_dones got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        int lat;
        logic busy1, s, eo, dn;
        logic [BW-1:0] b, bn;
        logic [RW-1:0] r;
        bus_if.ready = 1'b0;
        bus_if.error = 1'b0;
        tick();
        bus_if.Result = 32'hFFFF0000;
        bus_if.ready  = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b0;
        bus_if.ready = 1'b0;
        tick();
        tests_run++;
        if (bus_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_busy got=%b exp=0", bus_if.busy);
        end
        tests_run++;
        if (bus_if.bcd !== '0) begin
            tests_failed++;
            $display("FAIL abort_bcd got=%h exp=%h", bus_if.bcd, {BW{1'b0}});
        end
        tests_run++;
        if (bus_if.err_out !== 1'b0 || bus_if.sign !== 1'b0 || bus_if.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_flags got=%b%b%b exp=000", bus_if.err_out, bus_if.sign, bus_if.done);
        end
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.done === 1'b1) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done got=%0d exp=0", dones);
        end
        r = $urandom;
        convert(r, 1'b0, lat, busy1, b, s, eo, dn, bn);
        tests_run++;
        if (lat !== RW + 2 || b !== model_bcd(r) || s !== model_sign(r)) begin
            tests_failed++;
            $display("FAIL abort_reconvert got=lat %0d bcd %h sign %b exp=lat %0d bcd %h sign %b",
                     lat, b, s, RW + 2, model_bcd(r), model_sign(r));
        end
    endtask

    task automatic test_ready_through_reset();
        int dones;
        bus_if.Result = 32'd77;
        bus_if.error  = 1'b0;
        bus_if.ready  = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.done === 1'b1) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL ready_through_reset got=%0d dones exp=0", dones);
        end
        bus_if.ready = 1'b0;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset         = 1'b0;
        bus_if.ready  = 1'b0;
        bus_if.error  = 1'b0;
        bus_if.Result = '0;
        test_reset();
        test_directed();
        test_error();
        test_reset_abort();
        test_random();
        test_held_ready();
        test_ready_through_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_result_bcd_converter
